// File: rtl/sync_level_filter_if.sv
// Signal bundle between the level filter and its consumer; clock and reset stay outside.
interface sync_level_filter_if #(
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 enable;
    logic                 sig_in;
    logic                 count_clear;
    logic                 glitch_clear;
    logic                 level_out;
    logic                 rise_pulse;
    logic                 fall_pulse;
    logic [CNT_WIDTH-1:0] event_count;
    logic                 glitch_flag;

    modport master (
        output enable, sig_in, count_clear, glitch_clear,
        input  level_out, rise_pulse, fall_pulse, event_count, glitch_flag
    );

    modport slave (
        input  enable, sig_in, count_clear, glitch_clear,
        output level_out, rise_pulse, fall_pulse, event_count, glitch_flag
    );
endinterface

// File: rtl/sync_level_filter.sv
// Persistence filter for a synchronized level: accepts a change after FILTER_LEN
// consecutive differing samples, with edge pulses, saturating event count and glitch flag.
module sync_level_filter #(
    parameter int unsigned FILTER_LEN = 4,
    parameter logic        INIT_LEVEL = 1'b0,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input logic                 clock,
    input logic                 reset_n,
    sync_level_filter_if.slave  bus
);
    localparam logic [0:0] STABLE  = 1'b0;
    localparam logic [0:0] QUALIFY = 1'b1;
    localparam logic [7:0] FL8     = FILTER_LEN[7:0];

    logic [0:0]           state_q, state_d;
    logic [7:0]           qcnt_q, qcnt_d;
    logic                 level_q, level_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 glitch_q, glitch_d;
    logic                 accept;
    logic                 reject;

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        accept  = 1'b0;
        reject  = 1'b0;

        // Disabling abandons any qualification silently; no reject is raised.
        if (!bus.enable) begin
            state_d = STABLE;
            qcnt_d  = '0;
        end else begin
            case (state_q)
                STABLE: begin
                    if (bus.sig_in != level_q) begin
                        if (FILTER_LEN == 1) begin
                            accept = 1'b1;
                        end else begin
                            state_d = QUALIFY;
                            qcnt_d  = 8'd1;
                        end
                    end
                end
                QUALIFY: begin
                    if (bus.sig_in == level_q) begin
                        reject  = 1'b1;
                        state_d = STABLE;
                        qcnt_d  = '0;
                    end else if (qcnt_q + 8'd1 == FL8) begin
                        accept = 1'b1;
                    end else begin
                        qcnt_d = qcnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = STABLE;
                    qcnt_d  = '0;
                end
            endcase
        end

        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (accept) begin
            level_d = ~level_q;
            rise_d  = ~level_q;
            fall_d  = level_q;
            state_d = STABLE;
            qcnt_d  = '0;
        end

        cnt_d = cnt_q;
        if (bus.count_clear) begin
            cnt_d = accept ? CNT_WIDTH'(1) : '0;
        end else if (accept && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        glitch_d = glitch_q;
        if (reject) begin
            glitch_d = 1'b1;
        end else if (bus.glitch_clear) begin
            glitch_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= STABLE;
            qcnt_q   <= '0;
            level_q  <= INIT_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            cnt_q    <= '0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            qcnt_q   <= qcnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            cnt_q    <= cnt_d;
            glitch_q <= glitch_d;
        end
    end

    assign bus.level_out   = level_q;
    assign bus.rise_pulse  = rise_q;
    assign bus.fall_pulse  = fall_q;
    assign bus.event_count = cnt_q;
    assign bus.glitch_flag = glitch_q;
endmodule

// File: tb/tb_sync_level_filter.sv
// Four filter configurations driven in parallel and checked against a run-length model.
module tb_sync_level_filter;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic en = 1'b1, sig = 1'b0, cc = 1'b0, gc = 1'b0;

    int checks = 0;
    int failures = 0;

    // Configs: 0 FL=4 INIT=0 CW=8, 1 FL=1 CW=8, 2 FL=4 CW=2, 3 FL=4 INIT=1 CW=8
    int   FL   [4] = '{4, 1, 4, 4};
    logic INIT [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int   MAXC [4] = '{255, 255, 3, 255};

    logic m_level [4];
    logic m_rise  [4];
    logic m_fall  [4];
    logic m_gl    [4];
    int   m_run   [4];
    int   m_cnt   [4];

    logic       o_lvl  [4];
    logic       o_rise [4];
    logic       o_fall [4];
    logic       o_gl   [4];
    logic [7:0] o_cnt  [4];

    sync_level_filter_if #(.CNT_WIDTH(8)) if0 ();
    sync_level_filter_if #(.CNT_WIDTH(8)) if1 ();
    sync_level_filter_if #(.CNT_WIDTH(2)) if2 ();
    sync_level_filter_if #(.CNT_WIDTH(8)) if3 ();

    sync_level_filter #(.FILTER_LEN(4), .INIT_LEVEL(1'b0), .CNT_WIDTH(8)) u0 (.clock(clock), .reset_n(reset_n), .bus(if0));
    sync_level_filter #(.FILTER_LEN(1), .INIT_LEVEL(1'b0), .CNT_WIDTH(8)) u1 (.clock(clock), .reset_n(reset_n), .bus(if1));
    sync_level_filter #(.FILTER_LEN(4), .INIT_LEVEL(1'b0), .CNT_WIDTH(2)) u2 (.clock(clock), .reset_n(reset_n), .bus(if2));
    sync_level_filter #(.FILTER_LEN(4), .INIT_LEVEL(1'b1), .CNT_WIDTH(8)) u3 (.clock(clock), .reset_n(reset_n), .bus(if3));

    assign if0.enable = en;  assign if0.sig_in = sig;  assign if0.count_clear = cc;  assign if0.glitch_clear = gc;
    assign if1.enable = en;  assign if1.sig_in = sig;  assign if1.count_clear = cc;  assign if1.glitch_clear = gc;
    assign if2.enable = en;  assign if2.sig_in = sig;  assign if2.count_clear = cc;  assign if2.glitch_clear = gc;
    assign if3.enable = en;  assign if3.sig_in = sig;  assign if3.count_clear = cc;  assign if3.glitch_clear = gc;

    assign o_lvl[0] = if0.level_out;  assign o_rise[0] = if0.rise_pulse;  assign o_fall[0] = if0.fall_pulse;
    assign o_lvl[1] = if1.level_out;  assign o_rise[1] = if1.rise_pulse;  assign o_fall[1] = if1.fall_pulse;
    assign o_lvl[2] = if2.level_out;  assign o_rise[2] = if2.rise_pulse;  assign o_fall[2] = if2.fall_pulse;
    assign o_lvl[3] = if3.level_out;  assign o_rise[3] = if3.rise_pulse;  assign o_fall[3] = if3.fall_pulse;
    assign o_gl[0] = if0.glitch_flag; assign o_gl[1] = if1.glitch_flag;
    assign o_gl[2] = if2.glitch_flag; assign o_gl[3] = if3.glitch_flag;
    assign o_cnt[0] = if0.event_count;
    assign o_cnt[1] = if1.event_count;
    assign o_cnt[2] = {6'd0, if2.event_count};
    assign o_cnt[3] = if3.event_count;

    always #5 clock = ~clock;

    task automatic check_bit(input string tag, input int d, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0b expected=%0b", tag, d, obs, exp);
        end
    endtask

    task automatic check_cnt(input int d, input logic [7:0] obs, input int exp);
        checks++;
        assert (obs === 8'(exp)) else begin
            failures++;
            $error("FAIL event_count dut%0d observed=%0d expected=%0d", d, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            m_level[d] = INIT[d];
            m_rise[d]  = 1'b0;
            m_fall[d]  = 1'b0;
            m_gl[d]    = 1'b0;
            m_run[d]   = 0;
            m_cnt[d]   = 0;
        end
    endtask

    // A change is accepted once the run of samples differing from the
    // current level reaches FL; a run cut short counts as a glitch.
    task automatic model_edge();
        for (int d = 0; d < 4; d++) begin
            logic acc;
            logic rej;
            acc = 1'b0;
            rej = 1'b0;
            m_rise[d] = 1'b0;
            m_fall[d] = 1'b0;
            if (!en) begin
                m_run[d] = 0;
            end else if (sig != m_level[d]) begin
                m_run[d] = m_run[d] + 1;
                if (m_run[d] >= FL[d]) acc = 1'b1;
            end else begin
                rej = (m_run[d] > 0);
                m_run[d] = 0;
            end
            if (acc) begin
                m_level[d] = ~m_level[d];
                m_rise[d]  = m_level[d];
                m_fall[d]  = ~m_level[d];
                m_run[d]   = 0;
                m_cnt[d]   = cc ? 1 : ((m_cnt[d] + 1 > MAXC[d]) ? MAXC[d] : m_cnt[d] + 1);
            end else if (cc) begin
                m_cnt[d] = 0;
            end
            if (rej) m_gl[d] = 1'b1;
            else if (gc) m_gl[d] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 4; d++) begin
            check_bit("level_out", d, o_lvl[d], m_level[d]);
            check_bit("rise_pulse", d, o_rise[d], m_rise[d]);
            check_bit("fall_pulse", d, o_fall[d], m_fall[d]);
            check_bit("glitch_flag", d, o_gl[d], m_gl[d]);
            check_cnt(d, o_cnt[d], m_cnt[d]);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    // Reset lands mid-cycle, away from the clock edge, and releases before the next edge.
    task automatic async_reset();
        #1 reset_n = 1'b0;
        model_reset();
        #1 check_all();
        #3 reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1 check_all();
        reset_n = 1'b1;

        // 0->1 held: FL=4 pulses on the 4th differing edge.
        sig = 1'b1;
        step(); step(); step();
        check_bit("rise_before_k3", 0, o_rise[0], 1'b0);
        step();
        check_bit("rise_at_k3", 0, o_rise[0], 1'b1);
        check_bit("level_at_k3", 0, o_lvl[0], 1'b1);
        async_reset();
        check_bit("level_after_rst", 0, o_lvl[0], 1'b0);
        check_bit("level_init1_rst", 3, o_lvl[3], 1'b1);

        // After reset: full requalification; DUT3 sees no change while sig=1.
        step(); step(); step(); step(); step();

        // Glitch: 3 edges of 0 then back to 1, then clear.
        sig = 1'b0;
        step(); step(); step();
        sig = 1'b1;
        step();
        check_bit("glitch_set", 0, o_gl[0], 1'b1);
        gc = 1'b1;
        step();
        gc = 1'b0;
        check_bit("glitch_cleared", 0, o_gl[0], 1'b0);

        // Toggle every 2 cycles, 10 times.
        for (int t = 0; t < 10; t++) begin
            sig = ~sig;
            step(); step();
        end

        // Five accepts on the 2-bit counter, then a clear coincident with an accept.
        for (int t = 0; t < 5; t++) begin
            sig = ~sig;
            repeat (5) step();
        end
        sig = ~sig;
        step(); step(); step();
        cc = 1'b1;
        step();
        cc = 1'b0;
        check_cnt(2, o_cnt[2], 1);

        // Enable dropped mid-qualification, then re-raised.
        sig = ~sig;
        step(); step();
        en = 1'b0;
        step(); step();
        en = 1'b1;
        repeat (5) step();

        // Randomised runs of varying length with occasional disables, clears and resets.
        for (int r = 0; r < 400; r++) begin
            int len;
            sig = ~sig;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                en = ($urandom_range(0, 19) != 0);
                cc = ($urandom_range(0, 29) == 0);
                gc = ($urandom_range(0, 14) == 0);
                step();
            end
            if ($urandom_range(0, 99) == 0) async_reset();
        end
        en = 1'b1;
        cc = 1'b0;
        gc = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
